// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Each digit owns a slot of 2^cnt_width clock cycles. The first cycle of every
// slot is blanked (all digit enables off) so the segment lines can settle on
// the new digit's pattern without ghosting. Display content only changes at a
// frame boundary, so a frame is never drawn half old and half new.
//
// Parameters
//   w_digit    number of multiplexed digits (2..8)
//   cnt_width  refresh prescaler width; one digit slot = 2^cnt_width cycles
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   load            one-cycle request to latch din as the next frame content
//   din             per-digit segment patterns, active-high; byte k = digit k,
//                   bit7 = a ... bit1 = g, bit0 = h (decimal point)
//   abcdefgh        segment drive, active-low
//   digit           digit enables, active-low, at most one bit low
//   frame_start     one-cycle pulse in the first cycle of each new frame
//   update_pending  high while a loaded pattern waits for the frame boundary
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
  parameter int w_digit   = 4,
  parameter int cnt_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [8*w_digit-1:0]   din,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_start,
  output logic                   update_pending
);

  localparam int idx_w = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(w_digit - 1);

  // Active-low enables for the selected digit; all ones while blanked.
  function automatic logic [w_digit-1:0] digit_enables(
    input logic             blank,
    input logic [idx_w-1:0] sel
  );
    logic [w_digit-1:0] en;
    if (blank) begin
      en = {w_digit{1'b1}};
    end else begin
      en = ~(w_digit'(1) << sel);
    end
    return en;
  endfunction

  // Active-low segment drive for the selected digit of a frame buffer.
  function automatic logic [7:0] segment_drive(
    input logic [8*w_digit-1:0] frame_bits,
    input logic [idx_w-1:0]     sel
  );
    return ~frame_bits[{sel, 3'b000} +: 8];
  endfunction

  // Registered state
  logic [cnt_width-1:0]  cnt_r;
  logic [idx_w-1:0]      idx_r;
  logic [8*w_digit-1:0]  disp_r;
  logic [8*w_digit-1:0]  pend_r;
  logic                  pending_r;

  // Next-state values
  logic [cnt_width-1:0]  cnt_nxt_s;
  logic [idx_w-1:0]      idx_nxt_s;
  logic [8*w_digit-1:0]  disp_nxt_s;
  logic [8*w_digit-1:0]  pend_nxt_s;
  logic                  pending_nxt_s;
  logic                  slot_edge_s;
  logic                  swap_edge_s;

  // Next-state outputs, decoded from the next-state values so the registered
  // outputs always match the state they are registered alongside.
  logic [7:0]            abcdefgh_nxt_s;
  logic [w_digit-1:0]    digit_nxt_s;
  logic                  frame_start_nxt_s;

  // Slot and frame boundary detection plus prescaler/digit-index advance.
  always_comb begin
    cnt_nxt_s   = cnt_r + cnt_width'(1);
    slot_edge_s = (cnt_r == {cnt_width{1'b1}});
    swap_edge_s = 1'b0;
    idx_nxt_s   = idx_r;
    if (slot_edge_s) begin
      if (idx_r == last_idx) begin
        swap_edge_s = 1'b1;
        idx_nxt_s   = {idx_w{1'b0}};
      end else begin
        swap_edge_s = 1'b0;
        idx_nxt_s   = idx_r + idx_w'(1);
      end
    end else begin
      swap_edge_s = 1'b0;
      idx_nxt_s   = idx_r;
    end
  end

  // Frame buffer handling: a load on the swap edge goes straight to the
  // display; any other load parks in pend (last one wins) until the swap.
  always_comb begin
    disp_nxt_s    = disp_r;
    pend_nxt_s    = pend_r;
    pending_nxt_s = pending_r;
    if (swap_edge_s) begin
      pending_nxt_s = 1'b0;
      if (load) begin
        disp_nxt_s = din;
      end else if (pending_r) begin
        disp_nxt_s = pend_r;
      end else begin
        disp_nxt_s = disp_r;
      end
    end else begin
      if (load) begin
        pend_nxt_s    = din;
        pending_nxt_s = 1'b1;
      end else begin
        pend_nxt_s    = pend_r;
        pending_nxt_s = pending_r;
      end
    end
  end

  // Output decode from next-state values. The cycle where the prescaler
  // returns to zero is the blank cycle of the new slot; the segment lines
  // already carry the new digit's pattern during it.
  always_comb begin
    abcdefgh_nxt_s    = segment_drive(disp_nxt_s, idx_nxt_s);
    digit_nxt_s       = digit_enables(cnt_nxt_s == {cnt_width{1'b0}}, idx_nxt_s);
    frame_start_nxt_s = swap_edge_s;
  end

  // Scanner state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {cnt_width{1'b0}};
      idx_r     <= {idx_w{1'b0}};
      disp_r    <= {(8*w_digit){1'b0}};
      pend_r    <= {(8*w_digit){1'b0}};
      pending_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      disp_r    <= disp_nxt_s;
      pend_r    <= pend_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Registered display outputs; reset values equal the decode of reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abcdefgh       <= 8'hFF;
      digit          <= {w_digit{1'b1}};
      frame_start    <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      abcdefgh       <= abcdefgh_nxt_s;
      digit          <= digit_nxt_s;
      frame_start    <= frame_start_nxt_s;
      update_pending <= pending_nxt_s;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Bench for seven_segment_scanner with w_digit=4, cnt_width=2 (4-cycle slot,
// 16-cycle frame). Cycle k is the interval after the k-th rising edge since
// reset release (cycle 0 = reset state), so cnt = k%4 and idx = (k/4)%4.
// Stimulus pushes cycle-tagged expectations into a queue; a monitor samples
// the outputs on each falling edge and pops/compares entries due that cycle.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] din;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_start;
  logic        update_pending;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] mask;   // 3: segments, 2: digit, 1: frame_start, 0: update_pending
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fs;
    logic       up;
  } exp_t;

  exp_t sbq[$];

  seven_segment_scanner #(
    .w_digit   (4),
    .cnt_width (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .din            (din),
    .abcdefgh       (abcdefgh),
    .digit          (digit),
    .frame_start    (frame_start),
    .update_pending (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic push(input int c, input string n, input logic [3:0] m,
                      input logic [7:0] s, input logic [3:0] d,
                      input logic f, input logic u);
    exp_t e;
    e.cyc = c; e.name = n; e.mask = m; e.seg = s; e.dig = d; e.fs = f; e.up = u;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cyc == n) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_cyc timeout: cycle now %0d, required %0d", cyc, n);
  endtask

  // Hold load high so that it is sampled on rising edge k.
  task automatic load_at(input int k, input logic [31:0] d);
    wait_cyc(k - 1);
    load = 1'b1;
    din  = d;
    @(posedge clk);
    #1;
    load = 1'b0;
    din  = 32'hDEADBEEF;   // must be ignored while load is low
  endtask

  // Monitor: structural invariants every cycle, then scoreboard entries due.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ((digit == 4'hF) != ((cyc % 4) == 0)) begin
      failures++;
      $display("FAIL blank_cycle cycle %0d: digit %b, blank expected %0d", cyc, digit, (cyc % 4) == 0);
    end
    checks++;
    if ($countones(~digit) > 1) begin
      failures++;
      $display("FAIL one_hot cycle %0d: digit %b has more than one bit low", cyc, digit);
    end
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed: due cycle %0d, now cycle %0d", e.name, e.cyc, cyc);
      end else begin
        if (e.mask[3]) begin
          checks++;
          if (abcdefgh !== e.seg) begin
            failures++;
            $display("FAIL %s abcdefgh cycle %0d: got %h expected %h", e.name, cyc, abcdefgh, e.seg);
          end
        end
        if (e.mask[2]) begin
          checks++;
          if (digit !== e.dig) begin
            failures++;
            $display("FAIL %s digit cycle %0d: got %b expected %b", e.name, cyc, digit, e.dig);
          end
        end
        if (e.mask[1]) begin
          checks++;
          if (frame_start !== e.fs) begin
            failures++;
            $display("FAIL %s frame_start cycle %0d: got %b expected %b", e.name, cyc, frame_start, e.fs);
          end
        end
        if (e.mask[0]) begin
          checks++;
          if (update_pending !== e.up) begin
            failures++;
            $display("FAIL %s update_pending cycle %0d: got %b expected %b", e.name, cyc, update_pending, e.up);
          end
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    load     = 1'b0;
    din      = 32'h0;

    // Reset state and scan order after release.
    push(0,  "reset_state", 4'b1111, 8'hFF, 4'b1111, 1'b0, 1'b0);
    push(1,  "scan_c1",     4'b0100, 8'h00, 4'b1110, 1'b0, 1'b0);
    push(2,  "scan_c2",     4'b0101, 8'h00, 4'b1110, 1'b0, 1'b0);
    push(3,  "single_pend", 4'b0101, 8'h00, 4'b1110, 1'b0, 1'b1);
    push(4,  "scan_c4",     4'b0100, 8'h00, 4'b1111, 1'b0, 1'b0);
    push(5,  "scan_c5",     4'b0100, 8'h00, 4'b1101, 1'b0, 1'b0);
    // Single load at edge 3: old content until the frame boundary.
    push(15, "no_tear",     4'b1011, 8'hFF, 4'b0000, 1'b0, 1'b1);
    push(16, "swap_first",  4'b1111, 8'h03, 4'b1111, 1'b1, 1'b0);
    push(17, "swap_lit",    4'b1110, 8'h03, 4'b1110, 1'b0, 1'b0);
    push(20, "dig1_blank",  4'b1100, 8'h0D, 4'b1111, 1'b0, 1'b0);
    push(21, "dig1",        4'b1100, 8'h0D, 4'b1101, 1'b0, 1'b0);
    push(25, "dig2",        4'b1100, 8'h25, 4'b1011, 1'b0, 1'b0);
    push(29, "dig3",        4'b1100, 8'h9F, 4'b0111, 1'b0, 1'b0);
    push(32, "frame2",      4'b1010, 8'h03, 4'b0000, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    load_at(3, 32'h60DAF2FC);

    // Double load in frame 2: last wins, shown from cycle 48.
    push(41, "dbl_pend",    4'b0001, 8'h00, 4'b0000, 1'b0, 1'b1);
    push(44, "dbl_old",     4'b1000, 8'h9F, 4'b0000, 1'b0, 1'b0);
    push(48, "dbl_swap",    4'b1111, 8'hDD, 4'b1111, 1'b1, 1'b0);
    push(53, "dbl_d1",      4'b1000, 8'hDD, 4'b0000, 1'b0, 1'b0);
    push(58, "dbl_d2",      4'b1000, 8'hDD, 4'b0000, 1'b0, 1'b0);
    push(63, "dbl_d3",      4'b1001, 8'hDD, 4'b0000, 1'b0, 1'b0);
    load_at(34, 32'h11111111);
    load_at(40, 32'h22222222);

    // Load on the swap edge (edge 64), then a pending load at edge 67.
    push(64, "swap_load",   4'b1011, 8'h00, 4'b0000, 1'b1, 1'b0);
    push(65, "swap_nopend", 4'b0011, 8'h00, 4'b0000, 1'b0, 1'b0);
    push(66, "swap_nopend2",4'b1001, 8'h00, 4'b0000, 1'b0, 1'b0);
    push(68, "mid_pend",    4'b1001, 8'h00, 4'b0000, 1'b0, 1'b1);
    push(71, "mid_pend2",   4'b1001, 8'h00, 4'b0000, 1'b0, 1'b1);
    load_at(64, 32'hFFFFFFFF);
    load_at(67, 32'h12345678);

    // Asynchronous reset in cycle 72 (idx 2), between clock edges.
    wait_cyc(71);
    @(posedge clk);
    #1 reset = 1'b1;
    push(0,  "reset_mid",   4'b1111, 8'hFF, 4'b1111, 1'b0, 1'b0);
    push(1,  "post_d0",     4'b1001, 8'hFF, 4'b0000, 1'b0, 1'b0);
    push(5,  "post_d1",     4'b1000, 8'hFF, 4'b0000, 1'b0, 1'b0);
    push(9,  "post_d2",     4'b1000, 8'hFF, 4'b0000, 1'b0, 1'b0);
    push(13, "post_d3",     4'b1000, 8'hFF, 4'b0000, 1'b0, 1'b0);
    push(16, "post_swap",   4'b1011, 8'hFF, 4'b0000, 1'b1, 1'b0);
    push(17, "post_swap2",  4'b1001, 8'hFF, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Run three full frames for the blanking invariant.
    wait_cyc(52);

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
